// File: rtl/rcvbuf_pkg.sv
// Shared types and constants for the receive bit store sequencer.
package rcvbuf_pkg;
  localparam int BYTE_W         = 8;
  localparam int DEPTH_BITS_DEF = 10000;
  localparam int CNT_W_DEF      = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/rcvbuf_if.sv
// RX byte input and bit store drive signals of the receive buffer sequencer.
interface rcvbuf_if;
  import rcvbuf_pkg::*;

  logic              newdata;
  logic [BYTE_W-1:0] rbr;
  logic              shift_en;
  logic              feedbit;

  modport master (output newdata, output rbr, input shift_en, input feedbit);
  modport slave  (input newdata, input rbr, output shift_en, output feedbit);
endinterface

// File: rtl/rcvbuf_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; pulse_o is one cycle wide.
module rcvbuf_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], async_i};
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/rcvbuf_ctrl.sv
// Serializes received bytes LSB-first into the bit store on 1200 Hz ticks,
// then drains the store once DEPTH_BITS are held.
module rcvbuf_ctrl
  import rcvbuf_pkg::*;
#(
  parameter int DEPTH_BITS = DEPTH_BITS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             rcvbuf_clk,
  input  logic             rst,
  input  logic             clk_1200,
  rcvbuf_if.slave          bus,
  output logic [CNT_W-1:0] fill_count,
  output logic             full,
  output logic             draining,
  output logic             drain_done,
  output logic             overrun
);
  if (DEPTH_BITS <= 0 || (DEPTH_BITS % BYTE_W) != 0) begin : g_bad_depth
    $error("rcvbuf_ctrl: DEPTH_BITS must be a nonzero multiple of 8");
  end
  if (CNT_W < 1 || CNT_W > 30 || (2 ** CNT_W) <= DEPTH_BITS) begin : g_bad_cnt_w
    $error("rcvbuf_ctrl: CNT_W too narrow for DEPTH_BITS");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_BITS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic tick, nd_edge;

  rcvbuf_sync_edge u_sync_tick (
    .clk(rcvbuf_clk), .rst(rst), .async_i(clk_1200), .pulse_o(tick)
  );
  rcvbuf_sync_edge u_sync_nd (
    .clk(rcvbuf_clk), .rst(rst), .async_i(bus.newdata), .pulse_o(nd_edge)
  );

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              shift_en_q, shift_en_d;
  logic              feedbit_q, feedbit_d;
  logic              full_q, full_d;
  logic              done_pend_q, done_pend_d;
  logic              drain_done_q, drain_done_d;
  logic              overrun_q, overrun_d;

  always_ff @(posedge rcvbuf_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      bit_idx_q    <= '0;
      fill_q       <= '0;
      shift_en_q   <= 1'b0;
      feedbit_q    <= 1'b0;
      full_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      bit_idx_q    <= bit_idx_d;
      fill_q       <= fill_d;
      shift_en_q   <= shift_en_d;
      feedbit_q    <= feedbit_d;
      full_q       <= full_d;
      done_pend_q  <= done_pend_d;
      drain_done_q <= drain_done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    bit_idx_d    = bit_idx_q;
    fill_d       = fill_q;
    shift_en_d   = 1'b0;
    feedbit_d    = 1'b0;
    done_pend_d  = 1'b0;
    drain_done_d = done_pend_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE: begin
        // A tick arriving with the byte is dropped; shifting starts on the next tick.
        if (nd_edge) begin
          hold_d    = bus.rbr;
          bit_idx_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (nd_edge) overrun_d = 1'b1;
        if (tick && fill_q != DEPTH_C) begin
          shift_en_d = 1'b1;
          feedbit_d  = hold_q[bit_idx_q];
          fill_d     = fill_q + ONE_C;
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = (fill_d == DEPTH_C) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (nd_edge) overrun_d = 1'b1;
        if (tick && fill_q != '0) begin
          shift_en_d = 1'b1;
          fill_d     = fill_q - ONE_C;
          if (fill_q == ONE_C) begin
            state_d     = IDLE;
            done_pend_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    full_d = (fill_d == DEPTH_C);
  end

  assign bus.shift_en = shift_en_q;
  assign bus.feedbit  = feedbit_q;
  assign fill_count   = fill_q;
  assign full         = full_q;
  assign draining     = (state_q == DRAIN);
  assign drain_done   = drain_done_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_rcvbuf_ctrl.sv
// Directed scoreboard bench for rcvbuf_ctrl with a 16-bit store depth.
module tb_rcvbuf_ctrl;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_1200;
  logic [CW-1:0] fill_count;
  logic          full, draining, drain_done, overrun;

  rcvbuf_if bus ();

  rcvbuf_ctrl #(.DEPTH_BITS(DEPTH), .CNT_W(CW)) dut (
    .rcvbuf_clk(clk), .rst(rst), .clk_1200(clk_1200), .bus(bus),
    .fill_count(fill_count), .full(full), .draining(draining),
    .drain_done(drain_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          fb;
    logic [CW-1:0] fill;
    logic          full;
    logic          drn;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_miss = 0, n_shift = 0, n_done = 0, exp_done = 0;
  logic prev_shift = 1'b0;

  // Behavioural model of the expected shift stream
  int         m_state = 0, m_fill = 0, m_idx = 0;
  logic [7:0] m_hold = 8'h00;

  // Monitor: every shift pops one expectation; drain_done must follow a shift
  always @(negedge clk) begin
    if (bus.shift_en) begin
      n_shift++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_shift: got shift_en=1 fill=%0d, required no shift", fill_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({bus.feedbit, fill_count, full, draining} !== e) begin
          n_miss++;
          $display("FAIL shift_vec: got fb=%0b fill=%0d full=%0b drn=%0b, required fb=%0b fill=%0d full=%0b drn=%0b",
                   bus.feedbit, fill_count, full, draining, e.fb, e.fill, e.full, e.drn);
        end
      end
    end
    if (drain_done) begin
      n_done++;
      n_vec++;
      if (!(prev_shift && exp_done > 0)) begin
        n_miss++;
        $display("FAIL drain_done_pulse: got prev_shift=%0b pending=%0d, required 1 and >0", prev_shift, exp_done);
      end
      if (exp_done > 0) exp_done--;
    end
    prev_shift <= bus.shift_en;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_shift_en"}, int'(bus.shift_en), 0);
    chk({tag, "_feedbit"}, int'(bus.feedbit), 0);
    chk({tag, "_fill"}, int'(fill_count), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_draining"}, int'(draining), 0);
    chk({tag, "_drain_done"}, int'(drain_done), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic model_clear();
    m_state = 0; m_fill = 0; m_idx = 0; m_hold = 8'h00;
    exp_q.delete();
    exp_done = 0;
  endtask

  task automatic do_tick();
    exp_t e;
    if (m_state == 1) begin
      m_fill++;
      e.fb = m_hold[m_idx];
      if (m_idx == 7) m_state = (m_fill == DEPTH) ? 2 : 0;
      m_idx++;
      e.fill = CW'(m_fill); e.full = (m_fill == DEPTH); e.drn = (m_state == 2);
      exp_q.push_back(e);
    end else if (m_state == 2) begin
      m_fill--;
      if (m_fill == 0) begin m_state = 0; exp_done++; end
      e.fb = 1'b0; e.fill = CW'(m_fill); e.full = 1'b0; e.drn = (m_state == 2);
      exp_q.push_back(e);
    end
    clk_1200 = 1'b1;
    repeat (4) @(posedge clk);
    clk_1200 = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic do_byte(input logic [7:0] b);
    if (m_state == 0) begin m_hold = b; m_idx = 0; m_state = 1; end
    bus.rbr = b;
    bus.newdata = 1'b1;
    repeat (6) @(posedge clk);
    bus.newdata = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_byte_with_tick(input logic [7:0] b);
    m_hold = b; m_idx = 0; m_state = 1;
    bus.rbr = b;
    bus.newdata = 1'b1;
    clk_1200 = 1'b1;
    repeat (4) @(posedge clk);
    bus.newdata = 1'b0;
    clk_1200 = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero_outputs(tag);
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int s0;
    rst = 1'b1; clk_1200 = 1'b0; bus.newdata = 1'b0; bus.rbr = 8'h00;
    model_clear();
    repeat (3) @(posedge clk);
    // Activity while held in reset must not reach the bit store
    clk_1200 = 1'b1; bus.newdata = 1'b1; bus.rbr = 8'hFF;
    repeat (5) @(posedge clk);
    clk_1200 = 1'b0; bus.newdata = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("in_reset");
    chk("shifts_in_reset", n_shift, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(posedge clk);

    s0 = n_shift;
    do_byte(8'hA5);
    repeat (8) do_tick();
    @(negedge clk);
    chk("a5_fill", int'(fill_count), 8);
    chk("a5_full", int'(full), 0);
    chk("a5_draining", int'(draining), 0);
    chk("a5_shifts", n_shift - s0, 8);
    chk("a5_queue_left", exp_q.size(), 0);

    reset_pulse("async_rst");

    s0 = n_shift;
    do_byte(8'h0F);
    repeat (8) do_tick();
    do_byte(8'hF0);
    repeat (8) do_tick();
    @(negedge clk);
    chk("depth_full", int'(full), 1);
    chk("depth_draining", int'(draining), 1);
    chk("depth_fill", int'(fill_count), 16);
    repeat (16) do_tick();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drained_fill", int'(fill_count), 0);
    chk("drained_draining", int'(draining), 0);
    chk("drained_full", int'(full), 0);
    chk("drain_done_count", n_done, 1);
    chk("drain_done_pending", exp_done, 0);
    chk("depth_shifts", n_shift - s0, 32);

    reset_pulse("rst2");
    s0 = n_shift;
    do_byte_with_tick(8'h3C);
    @(negedge clk);
    chk("sim_no_shift", n_shift - s0, 0);
    repeat (8) do_tick();
    @(negedge clk);
    chk("sim_fill", int'(fill_count), 8);
    chk("sim_shifts", n_shift - s0, 8);

    reset_pulse("rst3");
    @(negedge clk);
    chk("ovr_initial", int'(overrun), 0);
    do_byte(8'h81);
    repeat (2) do_tick();
    do_byte(8'hFF);
    @(negedge clk);
    chk("ovr_set", int'(overrun), 1);
    repeat (6) do_tick();
    @(negedge clk);
    chk("ovr_fill", int'(fill_count), 8);
    do_byte(8'h42);
    repeat (8) do_tick();
    @(negedge clk);
    chk("ovr_sticky", int'(overrun), 1);
    chk("ovr_fill_full", int'(fill_count), 16);
    repeat (16) do_tick();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovr_drained", int'(fill_count), 0);

    reset_pulse("rst4");
    do_byte(8'h55);
    repeat (8) do_tick();
    do_byte(8'hAA);
    repeat (8) do_tick();
    repeat (9) do_tick();
    @(negedge clk);
    chk("mid_drain_fill", int'(fill_count), 7);
    chk("mid_drain_draining", int'(draining), 1);
    reset_pulse("rst_drain");
    @(negedge clk);
    chk("post_rst_draining", int'(draining), 0);
    do_byte(8'hC3);
    repeat (8) do_tick();
    @(negedge clk);
    chk("reload_fill", int'(fill_count), 8);
    chk("reload_draining", int'(draining), 0);
    chk("reload_full", int'(full), 0);
    chk("final_queue_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/rcvbuf_ctrl.md
# rcvbuf_ctrl

Sequencer for the receive bit store that sits between the RS-232 RX byte buffer and the main communications loopback. It detects each new received byte and serializes it LSB-first into the bit store, one shift per 1200 Hz bit tick. It counts stored bits and, once `DEPTH_BITS` are held, drains the store at the same tick rate so stored data propagates out of the chain. The bit store itself remains a plain clock-enabled flop chain driven by `shift_en`/`feedbit`.

## Interface
- `DEPTH_BITS`, 10000: bits held before drain; must be a nonzero multiple of 8.
- `CNT_W`, 14: fill counter width; must satisfy 2^CNT_W > DEPTH_BITS.
- `rcvbuf_clk`  in  1  sole clock (16x bit-rate domain); all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_1200`  in  1  asynchronous 1200 Hz reference; a synchronized rising edge is one bit tick.
- `newdata`  in  1  asynchronous; a synchronized rising edge means `rbr` holds a new byte.
- `rbr`  in  8  RX byte; stable for at least 4 `rcvbuf_clk` cycles after `newdata` rises.
- `shift_en`  out  1  one-cycle pulse; advances the bit store by one position.
- `feedbit`  out  1  serial input to the bit store; meaningful only while `shift_en`=1.
- `fill_count`  out  CNT_W  bits currently held.
- `full`  out  1  high while `fill_count`==`DEPTH_BITS`, from the last load shift to the first drain shift.
- `draining`  out  1  high in DRAIN.
- `drain_done`  out  1  one-cycle pulse when drain completes.
- `overrun`  out  1  sticky; set when a byte arrives and cannot be accepted; cleared only by `rst`.

## Operation
- Each of `clk_1200` and `newdata` passes through a 2-flop synchronizer, then a third flop for rising-edge detection. The results are `tick` and `nd_edge`, each a one-cycle pulse.
- State machine:
  - IDLE→LOAD on `nd_edge`. In the same cycle, `rbr` is captured into `hold[7:0]` and `bit_idx` is cleared to 0.
  - LOAD: on each `tick`, pulse `shift_en`, drive `feedbit`=`hold[bit_idx]`, increment `fill_count` and `bit_idx`.
  - LOAD exit after the 8th shift (`bit_idx`==7 with `tick`): go to DRAIN if the incremented `fill_count`==`DEPTH_BITS`, else IDLE.
  - DRAIN: on each `tick`, pulse `shift_en` with `feedbit`=0 and decrement `fill_count`. After the shift that brings `fill_count` to 0, go to IDLE and pulse `drain_done` in the following cycle.
- `nd_edge` is accepted only when the state is IDLE in that cycle. In LOAD or DRAIN, including the exit cycle itself, the byte is dropped and `overrun`←1.
- A `tick` in IDLE is ignored; no shift occurs.
- `tick` and `nd_edge` in the same IDLE cycle: the byte is captured and the state goes to LOAD. That tick causes no shift; the first shift occurs on the next tick.
- `fill_count` never exceeds `DEPTH_BITS` and never underflows. Because `DEPTH_BITS`%8==0, the full condition is only reached on a byte boundary.

## Timing
- Reset values: `shift_en`=0, `feedbit`=0, `fill_count`=0, `full`=0, `draining`=0, `drain_done`=0, `overrun`=0; state IDLE; `hold`=0; `bit_idx`=0.
- Reset asserted mid-LOAD or mid-DRAIN aborts immediately. The bit store is not flushed by this block.
- Edge latency is 3 `rcvbuf_clk` cycles from the input rising edge to the `tick`/`nd_edge` pulse.
- `shift_en` rises in the cycle after `tick`, because it is registered. `feedbit` is registered in the same cycle as `shift_en`.
- `shift_en` is at most 1 cycle wide; there is at least 15 cycles between pulses at nominal clocks.
- A byte load takes 8 ticks (about 6.67 ms). A full drain takes `DEPTH_BITS` ticks.
- `full`, `draining` and `fill_count` are registered outputs and update in the same cycle as the `shift_en` that changes them.

## Structure
- Package `rcvbuf_pkg` holds:
  - the state enum {IDLE, LOAD, DRAIN} (2 bits);
  - default `DEPTH_BITS` and `CNT_W` constants;
  - `BYTE_W`=8.
- One sub-module, `rcvbuf_sync_edge`: 2-flop synchronizer plus rising-edge detector, with async active-high reset to 0. It is instantiated twice, for `clk_1200` and `newdata`.
- Parameter checks (`DEPTH_BITS`%8, counter width) are done at elaboration.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 at once. Tick and `newdata` while in reset → no `shift_en`.
- Single byte `rbr`=0xA5 → exactly 8 `shift_en` pulses, one per tick. `feedbit` sequence is 1,0,1,0,0,1,0,1. `fill_count`=8, state returns to IDLE, `full`=0.
- `DEPTH_BITS`=16, bytes 0x0F then 0xF0:
  - after the 16th shift, `full`=1 and `draining`=1;
  - then 16 shifts with `feedbit`=0;
  - `fill_count` counts 16→0;
  - `drain_done` pulses once, 1 cycle after the last shift.
- Overrun: a `newdata` edge during the 3rd bit of LOAD → `overrun`=1 and the byte is dropped (`fill_count` ends at 8). A later accepted byte leaves `overrun` still 1.
- Simultaneous `tick` and `nd_edge` in IDLE → capture occurs and there is no shift in that cycle. The first `shift_en` follows the next tick.
- Reset during DRAIN at `fill_count`=7 → state IDLE and `fill_count`=0. A subsequent byte loads normally with `fill_count`=8.
